// File: rtl/addsub_pkg.sv
// Shared types for the add/sub arbiter slice.
// State encoding and operation codes.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_arbiter_if.sv
// Request/response bundle between two clients and the shared add/sub unit.
// master = client side, slave = arbiter side.
interface addsub_arbiter_if #(
    parameter int WIDTH = 16
);

    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_overflow;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result,
        input  rsp_carry, rsp_overflow,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result,
        output rsp_carry, rsp_overflow,
        input  rsp_ready
    );

endinterface

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder/subtractor with carry and signed overflow.
// Subtraction is a + ~b + 1, so carry=1 means no borrow.
module addsub_core
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] bm;
    logic             cin;

    always_comb begin
        bm  = (op == OP_ADD) ? b : ~b;
        cin = (op == OP_SUB);
        {carry, result} = {1'b0, a} + {1'b0, bm}
                        + {{WIDTH{1'b0}}, cin};
        // same-sign effective operands whose sum flips sign
        overflow = (a[WIDTH-1] == bm[WIDTH-1])
                && (result[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub core between two requesters.
// One operation in flight: IDLE accept, EXEC compute, RESP hold result.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    addsub_arbiter_if.slave bus
);

    state_t           state;
    state_t           state_nxt;
    logic             prio;
    logic             gnt0;
    logic             gnt1;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sel;
    logic             op_id;

    logic [WIDTH-1:0] core_res;
    logic             core_c;
    logic             core_v;

    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_id_q;
    logic             rsp_carry_q;
    logic             rsp_overflow_q;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a        (op_a),
        .b        (op_b),
        .op       (op_sel),
        .result   (core_res),
        .carry    (core_c),
        .overflow (core_v)
    );

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        unique case (state)
            IDLE: begin
                gnt0 = bus.req0_valid & (~bus.req1_valid | ~prio);
                gnt1 = bus.req1_valid & (~bus.req0_valid | prio);
                if (gnt0 | gnt1) state_nxt = EXEC;
            end
            EXEC: state_nxt = RESP;
            RESP: if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            prio           <= 1'b0;
            op_a           <= '0;
            op_b           <= '0;
            op_sel         <= 1'b0;
            op_id          <= 1'b0;
            rsp_result_q   <= '0;
            rsp_id_q       <= 1'b0;
            rsp_carry_q    <= 1'b0;
            rsp_overflow_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (gnt0 | gnt1) begin
                op_a   <= gnt1 ? bus.req1_a  : bus.req0_a;
                op_b   <= gnt1 ? bus.req1_b  : bus.req0_b;
                op_sel <= gnt1 ? bus.req1_op : bus.req0_op;
                op_id  <= gnt1;
            end
            if (state == EXEC) begin
                rsp_result_q   <= core_res;
                rsp_id_q       <= op_id;
                rsp_carry_q    <= core_c;
                rsp_overflow_q <= core_v;
            end
            // served requester drops to lowest priority
            if (state == RESP && bus.rsp_ready) prio <= ~rsp_id_q;
        end
    end

    assign bus.req0_ready   = gnt0 & ~reset;
    assign bus.req1_ready   = gnt1 & ~reset;
    assign bus.rsp_valid    = (state == RESP);
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_result   = rsp_result_q;
    assign bus.rsp_carry    = rsp_carry_q;
    assign bus.rsp_overflow = rsp_overflow_q;

endmodule
